// File: rtl/code_density_ctrl_pkg.sv
// Shared types for the code-density acquisition sequencer:
// FSM state encodings, RMW pipe stage codes and the drain length.
package code_density_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACQ   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // C0 is the acceptance cycle itself, so only C1/C2 need a register
  typedef enum logic [1:0] {
    RMW_IDLE = 2'd0,
    RMW_C1   = 2'd1,
    RMW_C2   = 2'd2
  } rmw_t;

  localparam int         DRAIN_CYCLES = 4;
  localparam logic [1:0] DRAIN_LAST   = 2'(DRAIN_CYCLES - 1);

endpackage

// File: rtl/code_density_ctrl_hist_ram.sv
// Single-port histogram memory with registered, enable-gated read.
// The read register holds its value while re is low.
module hist_ram #(
  parameter int AW = 10,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/code_density_ctrl.sv
// ADC code-density acquisition sequencer: gates the SPI ADC, bins words into a
// histogram RAM via a 3-cycle read-modify-write, then serves pipelined readout.
module code_density_ctrl
  import code_density_ctrl_pkg::*;
#(
  parameter int          WIDTH     = 10,
  parameter int          BIN_W     = 24,
  parameter int unsigned N_SAMPLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] adc_data,
  input  logic             adc_valid,
  output logic             adc_stop,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] rd_addr,
  output logic [BIN_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic [31:0]      sample_cnt,
  output logic             sample_lost
);

  state_t           state_reg, state_next;
  rmw_t             rmw_reg;
  logic [WIDTH-1:0] clr_addr_reg;
  logic [WIDTH-1:0] code_reg;
  logic [1:0]       drain_cnt_reg;
  logic [31:0]      cnt_reg;
  logic             lost_reg;
  logic             rd_p1_reg;
  logic             rd_valid_reg;
  logic [BIN_W-1:0] rd_data_reg;

  logic             ram_we, ram_re;
  logic [WIDTH-1:0] ram_addr;
  logic [BIN_W-1:0] ram_wdata, ram_rdata, bin_inc;

  logic in_acq, accept, drop, wr_c2, last_sample, rd_ok, clr_last, start_ok;

  assign in_acq      = (state_reg == ST_ACQ);
  assign accept      = in_acq && adc_valid && (rmw_reg == RMW_IDLE) && !abort;
  assign drop        = in_acq && adc_valid && (rmw_reg != RMW_IDLE) && !abort;
  assign wr_c2       = in_acq && (rmw_reg == RMW_C2) && !abort;
  assign last_sample = wr_c2 && ((cnt_reg + 32'd1) == 32'(N_SAMPLES));
  assign rd_ok       = rd_en && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign clr_last    = (clr_addr_reg == {WIDTH{1'b1}});
  assign start_ok    = start && !abort && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign bin_inc     = (ram_rdata == {BIN_W{1'b1}}) ? ram_rdata : ram_rdata + BIN_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: if (start)                        state_next = ST_CLEAR;
        ST_CLEAR:         if (clr_last)                     state_next = ST_ACQ;
        ST_ACQ:           if (last_sample)                  state_next = ST_DRAIN;
        ST_DRAIN:         if (drain_cnt_reg == DRAIN_LAST)  state_next = ST_DONE;
        default:                                            state_next = ST_IDLE;
      endcase
    end
  end

  // Moore outputs
  always_comb begin
    adc_stop = (state_reg != ST_ACQ);
    busy     = (state_reg == ST_CLEAR) || (state_reg == ST_ACQ) || (state_reg == ST_DRAIN);
    done     = (state_reg == ST_DONE);
  end

  // RAM port arbitration: exactly one user per state
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = rd_addr;
    ram_wdata = '0;
    case (state_reg)
      ST_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_addr_reg;
      end
      ST_ACQ: begin
        if (wr_c2) begin
          ram_we    = 1'b1;
          ram_addr  = code_reg;
          ram_wdata = bin_inc;
        end else if (accept) begin
          ram_re   = 1'b1;
          ram_addr = adc_data;
        end
      end
      ST_IDLE, ST_DONE: ram_re = rd_ok;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rmw_reg       <= RMW_IDLE;
      clr_addr_reg  <= '0;
      code_reg      <= '0;
      drain_cnt_reg <= '0;
      cnt_reg       <= '0;
      lost_reg      <= 1'b0;
      rd_p1_reg     <= 1'b0;
      rd_valid_reg  <= 1'b0;
      rd_data_reg   <= '0;
    end else begin
      clr_addr_reg  <= (state_reg == ST_CLEAR) ? clr_addr_reg + WIDTH'(1) : '0;
      drain_cnt_reg <= (state_reg == ST_DRAIN) ? drain_cnt_reg + 2'd1 : 2'd0;

      if (abort || !in_acq) begin
        rmw_reg <= RMW_IDLE;
      end else begin
        case (rmw_reg)
          RMW_IDLE: if (accept) begin
            rmw_reg  <= RMW_C1;
            code_reg <= adc_data;
          end
          RMW_C1:  rmw_reg <= RMW_C2;
          default: rmw_reg <= RMW_IDLE;
        endcase
      end

      if (start_ok) begin
        cnt_reg  <= '0;
        lost_reg <= 1'b0;
      end else begin
        if (wr_c2) cnt_reg  <= cnt_reg + 32'd1;
        if (drop)  lost_reg <= 1'b1;
      end

      rd_p1_reg    <= rd_ok;
      rd_valid_reg <= rd_p1_reg;
      if (rd_p1_reg) rd_data_reg <= ram_rdata;
    end
  end

  assign rd_data     = rd_data_reg;
  assign rd_valid    = rd_valid_reg;
  assign sample_cnt  = cnt_reg;
  assign sample_lost = lost_reg;

  hist_ram #(.AW(WIDTH), .DW(BIN_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_code_density_ctrl.sv
// Scoreboard bench: instance A (WIDTH=4, BIN_W=24, N=16), instance B (WIDTH=4, BIN_W=4, N=20).
module tb_code_density_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A
  logic        a_start = 0, a_abort = 0, a_adc_valid = 0, a_rd_en = 0;
  logic [3:0]  a_adc_data = 0, a_rd_addr = 0;
  logic        a_adc_stop, a_rd_valid, a_busy, a_done, a_lost;
  logic [23:0] a_rd_data;
  logic [31:0] a_cnt;
  // instance B
  logic        b_start = 0, b_abort = 0, b_adc_valid = 0, b_rd_en = 0;
  logic [3:0]  b_adc_data = 0, b_rd_addr = 0;
  logic        b_adc_stop, b_rd_valid, b_busy, b_done, b_lost;
  logic [3:0]  b_rd_data;
  logic [31:0] b_cnt;

  code_density_ctrl #(.WIDTH(4), .BIN_W(24), .N_SAMPLES(16)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
    .adc_data(a_adc_data), .adc_valid(a_adc_valid), .adc_stop(a_adc_stop),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .busy(a_busy), .done(a_done), .sample_cnt(a_cnt), .sample_lost(a_lost));

  code_density_ctrl #(.WIDTH(4), .BIN_W(4), .N_SAMPLES(20)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .adc_data(b_adc_data), .adc_valid(b_adc_valid), .adc_stop(b_adc_stop),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .busy(b_busy), .done(b_done), .sample_cnt(b_cnt), .sample_lost(b_lost));

  typedef struct packed {
    logic [23:0] data;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [23:0] bins_a [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s = %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitors: pop expected readout whenever rd_valid shows up
  always @(negedge clk) begin
    if (a_rd_valid) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_rd_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_rd_data", {8'd0, a_rd_data}, {8'd0, e.data});
        chk("a_rd_lag", cyc - e.cyc, 32'd2);
      end
    end
    if (b_rd_valid) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_rd_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_rd_data", {28'd0, b_rd_data}, {8'd0, e.data});
        chk("b_rd_lag", cyc - e.cyc, 32'd2);
      end
    end
  end

  task automatic strobe_a(input logic [3:0] code);
    a_adc_data = code; a_adc_valid = 1'b1;
    tick(1);
    a_adc_valid = 1'b0;
  endtask

  task automatic strobe_b(input logic [3:0] code);
    b_adc_data = code; b_adc_valid = 1'b1;
    tick(1);
    b_adc_valid = 1'b0;
  endtask

  task automatic pulse_start_a();
    a_start = 1'b1; tick(1); a_start = 1'b0;
  endtask

  task automatic wait_acq_a(input string name);
    for (int i = 0; i < 100 && a_adc_stop; i++) tick(1);
    chk(name, a_adc_stop, 1'b0);
  endtask

  // Back-to-back readout of every A bin
  task automatic read_all_a();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      a_rd_en = 1'b1; a_rd_addr = 4'(i);
      e.data = bins_a[i]; e.cyc = cyc;
      qa.push_back(e);
      tick(1);
    end
    a_rd_en = 1'b0;
    tick(4);
    chk("a_readout_drained", qa.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    tick(3);
    rst = 1'b0;
    // reset state
    chk("rst_adc_stop", a_adc_stop, 1);
    chk("rst_rd_data", a_rd_data, 0);
    chk("rst_rd_valid", a_rd_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_sample_cnt", a_cnt, 0);
    chk("rst_sample_lost", a_lost, 0);

    // B: saturation at 15 with 20 samples, spacing exactly 3 cycles
    b_start = 1'b1; tick(1); b_start = 1'b0;
    for (int i = 0; i < 100 && b_adc_stop; i++) tick(1);
    chk("b_in_acq", b_adc_stop, 0);
    for (int i = 0; i < 20; i++) begin
      strobe_b(4'd0);
      tick(2);
    end
    for (int i = 0; i < 20 && !b_done; i++) tick(1);
    chk("b_done", b_done, 1);
    chk("b_sample_cnt", b_cnt, 20);
    chk("b_sample_lost", b_lost, 0);
    foreach (qb[i]) ;
    for (int i = 0; i < 3; i++) begin
      logic [3:0] addr_tab [3];
      addr_tab = '{4'd0, 4'd1, 4'd15};
      b_rd_en = 1'b1; b_rd_addr = addr_tab[i];
      e.data = (i == 0) ? 24'd15 : 24'd0; e.cyc = cyc;
      qb.push_back(e);
      tick(1);
    end
    b_rd_en = 1'b0;
    tick(4);

    // A run 1: 16 strobes of code 5, 300 cycles apart
    pulse_start_a();
    chk("a_busy_clear", a_busy, 1);
    wait_acq_a("a_run1_acq");
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("a_cnt_before_last", a_cnt, 15);
      strobe_a(4'd5);
      if (i < 15) tick(299);
    end
    tick(1);
    chk("a_stop_before_c2", a_adc_stop, 0);
    tick(1);
    chk("a_stop_after_last", a_adc_stop, 1);
    chk("a_cnt_16", a_cnt, 16);
    tick(3);
    chk("a_done_drain3", a_done, 0);
    tick(1);
    chk("a_done_drain4", a_done, 1);
    chk("a_busy_done", a_busy, 0);
    foreach (bins_a[i]) bins_a[i] = 24'd0;
    bins_a[5] = 24'd16;
    read_all_a();

    // A run 2 from DONE: CLEAR length, dropped strobe, rd_en ignored in ACQ, abort
    pulse_start_a();
    chk("a_cnt_cleared", a_cnt, 0);
    tick(15);
    chk("a_clear_cycle16", a_adc_stop, 1);
    tick(1);
    chk("a_clear_exit", a_adc_stop, 0);
    strobe_a(4'd3);
    tick(1);
    strobe_a(4'd3);
    chk("a_lost_set", a_lost, 1);
    chk("a_cnt_one", a_cnt, 1);
    tick(5);
    for (int i = 0; i < 6; i++) begin
      strobe_a(4'd9);
      tick(4);
    end
    chk("a_cnt_seven", a_cnt, 7);
    a_rd_en = 1'b1; a_rd_addr = 4'd9;
    tick(3);
    a_rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("a_acq_rd_valid", a_rd_valid, 0);
      tick(1);
    end
    strobe_a(4'd12);
    a_abort = 1'b1; tick(1); a_abort = 1'b0;
    chk("a_abort_stop", a_adc_stop, 1);
    chk("a_abort_busy", a_busy, 0);
    chk("a_abort_cnt", a_cnt, 7);
    chk("a_abort_lost_sticky", a_lost, 1);
    tick(3);
    foreach (bins_a[i]) bins_a[i] = 24'd0;
    bins_a[3] = 24'd1;
    bins_a[9] = 24'd6;
    read_all_a();

    // A run 3 from IDLE: sample_lost cleared, CLEAR zeroes every bin
    pulse_start_a();
    chk("a_lost_cleared", a_lost, 0);
    wait_acq_a("a_run3_acq");
    a_abort = 1'b1; tick(1); a_abort = 1'b0;
    foreach (bins_a[i]) bins_a[i] = 24'd0;
    read_all_a();

    // Leave rd_data nonzero, then reset in the middle of ACQ
    pulse_start_a();
    wait_acq_a("a_run4_acq");
    strobe_a(4'd7);
    tick(3);
    strobe_a(4'd7);
    tick(1);
    strobe_a(4'd7);
    chk("a_pre_rst_lost", a_lost, 1);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("mid_rst_adc_stop", a_adc_stop, 1);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_done", a_done, 0);
    chk("mid_rst_cnt", a_cnt, 0);
    chk("mid_rst_lost", a_lost, 0);
    chk("mid_rst_rd_valid", a_rd_valid, 0);
    chk("mid_rst_rd_data", a_rd_data, 0);
    tick(4);
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
